// File: rtl/y86_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : y86_pkg
// Brief    : Y86-64 icodes, register id, status codes and pipeline-control FSM
//            state shared by the fetch, decode, execute and control blocks.
// Revision : 1.0
//------------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } ctl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_controller_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_hazard_controller_if
// Brief    : Stage-content inputs and register-control outputs of the hazard
//            controller; master = pipeline side, slave = controller side.
// Revision : 1.0
//------------------------------------------------------------------------------
interface pipe_hazard_controller_if;

  logic       start;
  logic [3:0] d_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] e_icode;
  logic [3:0] e_dstM;
  logic       e_cond;
  logic [3:0] m_icode;
  logic [2:0] m_stat;
  logic [2:0] w_stat;
  logic       w_valid;

  logic       f_stall;
  logic       d_stall;
  logic       w_stall;
  logic       d_bubble;
  logic       e_bubble;
  logic       m_bubble;
  logic       set_cc_en;
  logic       halted;
  logic [2:0] final_stat;

  modport master (
    output start, d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cond,
           m_icode, m_stat, w_stat, w_valid,
    input  f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble,
           set_cc_en, halted, final_stat
  );

  modport slave (
    input  start, d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cond,
           m_icode, m_stat, w_stat, w_valid,
    output f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble,
           set_cc_en, halted, final_stat
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_controller_sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sat_counter
// Brief    : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
//------------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_hazard_controller
// Brief    : Y86-64 stall/bubble/CC control with run/drain/halt sequencing.
//            Optional counters enabled by PIPE_PERF_COUNTERS_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
module pipe_hazard_controller
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  pipe_hazard_controller_if.slave   ctl
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]          perf_cycles,
  output logic [CNT_W-1:0]          perf_stalls,
  output logic [CNT_W-1:0]          perf_bubbles,
  output logic [CNT_W-1:0]          perf_retired
`endif
);

  ctl_state_t r_state;
  ctl_state_t w_next;
  logic       r_halted;
  logic [2:0] r_final_stat;

  logic w_load_use, w_ret_pend, w_mispred, w_exc_m, w_exc_w;
  logic w_f_stall, w_d_stall, w_w_stall;
  logic w_d_bubble, w_e_bubble, w_m_bubble, w_set_cc_en;

  assign w_load_use = ((ctl.e_icode == IMRMOVQ) || (ctl.e_icode == IPOPQ)) &&
                      (ctl.e_dstM != RNONE) &&
                      ((ctl.e_dstM == ctl.d_srcA) || (ctl.e_dstM == ctl.d_srcB));
  assign w_ret_pend = (ctl.d_icode == IRET) || (ctl.e_icode == IRET) ||
                      (ctl.m_icode == IRET);
  assign w_mispred  = (ctl.e_icode == IJXX) && !ctl.e_cond;
  assign w_exc_m    = (ctl.m_stat != SAOK);
  assign w_exc_w    = (ctl.w_stat != SAOK);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_f_stall   = 1'b0;
    w_d_stall   = 1'b0;
    w_w_stall   = 1'b0;
    w_d_bubble  = 1'b0;
    w_e_bubble  = 1'b0;
    w_m_bubble  = 1'b0;
    w_set_cc_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_f_stall  = 1'b1;
        w_d_stall  = 1'b1;
        w_w_stall  = 1'b1;
        w_d_bubble = 1'b1;
        w_e_bubble = 1'b1;
        w_m_bubble = 1'b1;
        if (ctl.start) w_next = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        w_f_stall   = w_load_use | w_ret_pend;
        w_d_stall   = w_load_use;
        // A held decode register must not also be squashed.
        w_d_bubble  = (w_mispred | (w_ret_pend & ~w_load_use)) & ~w_d_stall;
        w_e_bubble  = w_mispred | w_load_use;
        w_m_bubble  = w_exc_m | w_exc_w;
        w_w_stall   = w_exc_w;
        w_set_cc_en = ~w_exc_m & ~w_exc_w;
        if (w_exc_w) begin
          w_next = ST_HALTED;
        end else if ((r_state == ST_RUN) && w_exc_m) begin
          w_next = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        w_f_stall = 1'b1;
        w_d_stall = 1'b1;
        w_w_stall = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_halted     <= 1'b0;
      r_final_stat <= SAOK;
    end else begin
      r_halted <= (r_state == ST_HALTED);
      if ((r_state != ST_HALTED) && (w_next == ST_HALTED)) begin
        r_final_stat <= ctl.w_stat;
      end
    end
  end

  assign ctl.f_stall    = w_f_stall;
  assign ctl.d_stall    = w_d_stall;
  assign ctl.w_stall    = w_w_stall;
  assign ctl.d_bubble   = w_d_bubble;
  assign ctl.e_bubble   = w_e_bubble;
  assign ctl.m_bubble   = w_m_bubble;
  assign ctl.set_cc_en  = w_set_cc_en;
  assign ctl.halted     = r_halted;
  assign ctl.final_stat = r_final_stat;

`ifdef PIPE_PERF_COUNTERS_EN
  logic w_active;
  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_cycles (
    .clock(clock), .reset_n(reset_n), .inc(w_active), .count(perf_cycles));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_stalls (
    .clock(clock), .reset_n(reset_n), .inc(w_active & w_f_stall), .count(perf_stalls));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_bubbles (
    .clock(clock), .reset_n(reset_n),
    .inc(w_active & (w_d_bubble | w_e_bubble | w_m_bubble)), .count(perf_bubbles));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_retired (
    .clock(clock), .reset_n(reset_n),
    .inc(w_active & ctl.w_valid & (ctl.w_stat == SAOK)), .count(perf_retired));
`else
  // w_valid and CNT_W only feed the counters.
  localparam int C_UNUSED_CNT_W = CNT_W;
  logic w_unused_ok;
  assign w_unused_ok = ctl.w_valid & (C_UNUSED_CNT_W > 0);
`endif

endmodule
`default_nettype wire
